// File: rtl/uart_packet_tx.sv
// uart_packet_tx
//   UART packet transmitter for coordinate updates between boards.
//   Packs NUM_FIELDS fields of FIELD_W bits (field 0 in the MSBs) into
//   NB = ceil(NUM_FIELDS*FIELD_W/8) bytes, MSB-first, with the last byte
//   zero-padded in its LSBs. A frame is SYNC_BYTE, the payload bytes and an
//   XOR checksum of the payload bytes. Each byte goes out as 8N1, LSB first,
//   and every bit lasts BAUD_DIV = CLK_HZ/BAUD cycles. GAP_BITS idle bit
//   times follow every frame.
//   A one-deep pending slot takes updates that arrive while a frame is in
//   flight; a newer update replaces an unsent one (latest wins).
//
// Ports
//   clk_in               system clock
//   rst_in               synchronous, active-high reset
//   data_in              concatenated fields, field 0 in the MSBs
//   valid_in             one-cycle strobe: capture data_in
//   tx_out               serial line, idles high (registered)
//   busy_out             frame or gap in progress, or a payload waiting to start
//   pending_out          pending slot holds an unsent payload
//   frame_done_out       pulse in the last cycle of the checksum stop bit
//   overwrite_count_out  number of pending-slot overwrites, saturates at 255
//
// Handshake: valid_in has no ready. In IDLE with an empty slot it starts a
// frame at once; otherwise it writes the pending slot. Nothing is stalled.
module uart_packet_tx #(
  parameter int          CLK_HZ     = 65_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          NUM_FIELDS = 4,
  parameter int          FIELD_W    = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          GAP_BITS   = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_FIELDS*FIELD_W-1:0] data_in,
  input  logic                          valid_in,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic                          pending_out,
  output logic                          frame_done_out,
  output logic [7:0]                    overwrite_count_out
);

  localparam int DW       = NUM_FIELDS * FIELD_W;
  localparam int NB       = (DW + 7) / 8;
  localparam int PW       = NB * 8;
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int BCW      = $clog2(NB + 2);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  // Payload left-aligned in a whole number of bytes; pad bits are zero.
  function automatic logic [PW-1:0] pad_word(input logic [DW-1:0] w);
    logic [PW-1:0] r;
    r = '0;
    r[PW-1 -: DW] = w;
    return r;
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [PW-1:0] w);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < NB; i++) x = x ^ w[i*8 +: 8];
    return x;
  endfunction

  state_t          state_q, state_n;
  logic [CW-1:0]   baud_q, baud_n;
  logic [2:0]      bit_q, bit_n;
  logic [BCW-1:0]  byte_q, byte_n;   // 0 = SYNC, 1..NB = payload, NB+1 = checksum
  logic [3:0]      gap_q, gap_n;
  logic [7:0]      shift_q, shift_n; // byte currently on the line, bit 0 is next out
  logic [PW-1:0]   payload_q, payload_n; // payload bytes not yet loaded, top byte next
  logic [7:0]      chk_q, chk_n;
  logic [DW-1:0]   pend_q, pend_n;
  logic            pending_q, pending_n;
  logic [7:0]      ovf_q, ovf_n;
  logic            tx_n;

  logic bit_end;
  logic last_byte;
  logic launch;       // start a new frame at this edge
  logic launch_pend;  // ... taking its payload from the pending slot
  logic frame_end;    // final bit time of the frame (stop or gap) ends now

  always_comb begin
    state_n     = state_q;
    baud_n      = baud_q;
    bit_n       = bit_q;
    byte_n      = byte_q;
    gap_n       = gap_q;
    shift_n     = shift_q;
    payload_n   = payload_q;
    chk_n       = chk_q;
    pend_n      = pend_q;
    pending_n   = pending_q;
    ovf_n       = ovf_q;
    tx_n        = 1'b1;
    launch      = 1'b0;
    launch_pend = 1'b0;
    frame_end   = 1'b0;

    bit_end   = (baud_q == '0);
    last_byte = (byte_q == BCW'(NB + 1));

    if (!bit_end) baud_n = baud_q - CW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          launch      = 1'b1;
          launch_pend = 1'b1;
        end else if (valid_in) begin
          launch = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = '0;
          baud_n  = BAUD_RELOAD;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_n = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_n   = bit_q + 3'd1;
            shift_n = shift_q >> 1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_n = BAUD_RELOAD;
          if (last_byte) begin
            if (GAP_BITS > 0) begin
              state_n = S_GAP;
              gap_n   = 4'(GAP_BITS - 1);
            end else begin
              frame_end = 1'b1;
            end
          end else begin
            state_n = S_START;
            byte_n  = byte_q + BCW'(1);
            if (byte_q == BCW'(NB)) begin
              shift_n = chk_q;
            end else begin
              shift_n   = payload_q[PW-1 -: 8];
              payload_n = payload_q << 8;
            end
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          baud_n = BAUD_RELOAD;
          if (gap_q == '0) frame_end = 1'b1;
          else             gap_n     = gap_q - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A payload already waiting when the frame ends starts on the very next
    // cycle, so queued frames run back-to-back after the gap.
    if (frame_end) begin
      state_n = S_IDLE;
      if (pending_q) begin
        launch      = 1'b1;
        launch_pend = 1'b1;
      end
    end

    if (launch) begin
      payload_n = pad_word(launch_pend ? pend_q : data_in);
      chk_n     = xor_bytes(payload_n);
      state_n   = S_START;
      baud_n    = BAUD_RELOAD;
      bit_n     = '0;
      byte_n    = '0;
      shift_n   = SYNC_BYTE;
    end

    // Any strobe not started directly from IDLE lands in the slot. Replacing
    // an entry that is not being consumed this same cycle is an overwrite.
    if (valid_in && !(launch && !launch_pend)) begin
      pend_n    = data_in;
      pending_n = 1'b1;
      if (pending_q && !launch_pend && ovf_q != 8'hFF) ovf_n = ovf_q + 8'd1;
    end else if (launch_pend) begin
      pending_n = 1'b0;
    end

    if (state_n == S_START)     tx_n = 1'b0;
    else if (state_n == S_DATA) tx_n = shift_n[0];
    else                        tx_n = 1'b1;

    busy_out            = (state_q != S_IDLE) || pending_q;
    pending_out         = pending_q;
    frame_done_out      = (state_q == S_STOP) && last_byte && bit_end;
    overwrite_count_out = ovf_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      gap_q     <= '0;
      shift_q   <= '0;
      payload_q <= '0;
      chk_q     <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      ovf_q     <= '0;
      tx_out    <= 1'b1;
    end else begin
      state_q   <= state_n;
      baud_q    <= baud_n;
      bit_q     <= bit_n;
      byte_q    <= byte_n;
      gap_q     <= gap_n;
      shift_q   <= shift_n;
      payload_q <= payload_n;
      chk_q     <= chk_n;
      pend_q    <= pend_n;
      pending_q <= pending_n;
      ovf_q     <= ovf_n;
      tx_out    <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx. Two instances share clock and reset:
//   dut_a: 2 fields x 12 bits, GAP_BITS=0 (3 payload bytes, 500-cycle frame)
//   dut_b: 1 field  x 12 bits, GAP_BITS=2 (2 payload bytes, 400+20 cycles)
// BAUD_DIV = 10 for both. Line bytes are decoded from tx and compared with
// hand-computed frames held in exp_q.
module tb_uart_packet_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] data_a;
  logic        valid_a;
  logic        tx_a, busy_a, pend_a, fd_a;
  logic [7:0]  ovf_a;
  logic [11:0] data_b;
  logic        valid_b;
  logic        tx_b, busy_b, pend_b, fd_b;
  logic [7:0]  ovf_b;

  uart_packet_tx #(
    .CLK_HZ(10), .BAUD(1), .NUM_FIELDS(2), .FIELD_W(12),
    .SYNC_BYTE(8'hA5), .GAP_BITS(0)
  ) dut_a (
    .clk_in(clk), .rst_in(rst), .data_in(data_a), .valid_in(valid_a),
    .tx_out(tx_a), .busy_out(busy_a), .pending_out(pend_a),
    .frame_done_out(fd_a), .overwrite_count_out(ovf_a)
  );

  uart_packet_tx #(
    .CLK_HZ(10), .BAUD(1), .NUM_FIELDS(1), .FIELD_W(12),
    .SYNC_BYTE(8'hA5), .GAP_BITS(2)
  ) dut_b (
    .clk_in(clk), .rst_in(rst), .data_in(data_b), .valid_in(valid_b),
    .tx_out(tx_b), .busy_out(busy_b), .pending_out(pend_b),
    .frame_done_out(fd_b), .overwrite_count_out(ovf_b)
  );

  // ---------------- clock/cycle bookkeeping ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int fd_cnt_a = 0;
  int fd_cyc_a = -1;
  int fd_cnt_b = 0;
  int fd_cyc_b = -1;
  always @(negedge clk) begin
    if (fd_a === 1'b1) begin fd_cnt_a++; fd_cyc_a = cyc; end
    if (fd_b === 1'b1) begin fd_cnt_b++; fd_cyc_b = cyc; end
  end

  logic sel;  // 0 = watch dut_a, 1 = watch dut_b
  logic tx_sel, busy_sel;
  assign tx_sel   = sel ? tx_b : tx_a;
  assign busy_sel = sel ? busy_b : busy_a;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [39:0] bytes, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(bytes[39 - 8*i -: 8]);
  endtask

  // Receive one byte from the selected line; t0 = cycle of its first low.
  task automatic rx_one(output int t0);
    logic [7:0] b;
    logic [7:0] e;
    int n;
    n = 0;
    while (tx_sel !== 1'b0 && n < 2000) begin tick(); n++; end
    check_val("start_found", 32'(n < 2000), 32'd1);
    t0 = cyc;
    repeat (5) tick();
    check_val("start_bit", 32'(tx_sel), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (10) tick();
      b[i] = tx_sel;
    end
    repeat (10) tick();
    check_val("stop_bit", 32'(tx_sel), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check_val("line_byte", 32'(b), 32'(e));
  endtask

  task automatic wait_busy_low(output int t);
    int n;
    n = 0;
    while (busy_sel !== 1'b0 && n < 3000) begin tick(); n++; end
    check_val("busy_fall_found", 32'(n < 3000), 32'd1);
    t = cyc;
  endtask

  task automatic pulse_a(input logic [23:0] d);
    data_a  = d;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [11:0] d);
    data_b  = d;
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int t, t_first, t2, t_last, lows, n;

  initial begin
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0; sel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // ---- reset state ----
    check_val("rst_tx", 32'(tx_a), 32'd1);
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_pending", 32'(pend_a), 32'd0);
    check_val("rst_frame_done", 32'(fd_a), 32'd0);
    check_val("rst_ovf", 32'(ovf_a), 32'd0);

    // ---- basic frame, 2x12-bit fields ----
    pulse_a(24'h38BA15);
    check_val("accept_tx_low", 32'(tx_a), 32'd0);
    check_val("accept_busy", 32'(busy_a), 32'd1);
    push_bytes({8'hA5, 8'h38, 8'hBA, 8'h15, 8'h97}, 5);
    rx_one(t_first);
    repeat (4) rx_one(t);
    wait_busy_low(t);
    check_val("frame_len", 32'(t - t_first), 32'd500);
    check_val("frame_done_count", 32'(fd_cnt_a), 32'd1);
    check_val("frame_done_cycle", 32'(fd_cyc_a), 32'(t_first + 499));

    // ---- latest-wins pending slot ----
    repeat (5) tick();
    pulse_a(24'h38BA15);
    push_bytes({8'hA5, 8'h38, 8'hBA, 8'h15, 8'h97}, 5);
    rx_one(t_first);
    rx_one(t);
    pulse_a(24'h111222);
    check_val("p1_pending", 32'(pend_a), 32'd1);
    check_val("p1_ovf", 32'(ovf_a), 32'd0);
    rx_one(t);
    pulse_a(24'h5A3C07);
    check_val("p2_ovf", 32'(ovf_a), 32'd1);
    rx_one(t);
    rx_one(t);
    push_bytes({8'hA5, 8'h5A, 8'h3C, 8'h07, 8'h61}, 5);
    rx_one(t2);
    check_val("back_to_back", 32'(t2 - t_first), 32'd500);
    check_val("p2_pending_clr", 32'(pend_a), 32'd0);
    repeat (4) rx_one(t);
    wait_busy_low(t);
    check_val("no_double_send", 32'(t - t2), 32'd500);

    // ---- reset mid-frame ----
    repeat (5) tick();
    pulse_a(24'h38BA15);
    push_bytes({8'hA5, 8'h38, 8'h00, 8'h00, 8'h00}, 2);
    rx_one(t);
    rx_one(t);
    n = 0;
    while (tx_a !== 1'b0 && n < 50) begin tick(); n++; end
    check_val("byte2_found", 32'(n < 50), 32'd1);
    repeat (30) tick();
    pulse_a(24'h777777);
    check_val("pre_rst_pending", 32'(pend_a), 32'd1);
    rst = 1'b1;
    tick();
    check_val("midrst_tx", 32'(tx_a), 32'd1);
    check_val("midrst_busy", 32'(busy_a), 32'd0);
    check_val("midrst_pending", 32'(pend_a), 32'd0);
    check_val("midrst_ovf", 32'(ovf_a), 32'd0);
    check_val("midrst_frame_done", 32'(fd_a), 32'd0);
    rst = 1'b0;
    lows = 0;
    repeat (150) begin tick(); if (tx_a !== 1'b1) lows++; end
    check_val("quiet_after_rst", 32'(lows), 32'd0);
    pulse_a(24'h0F0FFF);
    push_bytes({8'hA5, 8'h0F, 8'h0F, 8'hFF, 8'hFF}, 5);
    rx_one(t_first);
    repeat (4) rx_one(t);
    wait_busy_low(t);
    check_val("post_rst_len", 32'(t - t_first), 32'd500);

    // ---- overwrite counter saturation ----
    pulse_a(24'h123456);
    valid_a = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data_a = 24'(i);
      tick();
      if (i == 99) check_val("ovf_99", 32'(ovf_a), 32'd99);
    end
    valid_a = 1'b0;
    check_val("ovf_sat", 32'(ovf_a), 32'd255);
    check_val("sat_pending", 32'(pend_a), 32'd1);
    wait_busy_low(t);
    check_val("ovf_hold", 32'(ovf_a), 32'd255);

    // ---- single 12-bit field, zero padding, gap ----
    sel = 1'b1;
    check_val("b_idle_tx", 32'(tx_b), 32'd1);
    check_val("b_idle_busy", 32'(busy_b), 32'd0);
    pulse_b(12'hABC);
    push_bytes({8'hA5, 8'hAB, 8'hC0, 8'h6B, 8'h00}, 4);
    rx_one(t_first);
    repeat (3) rx_one(t);
    wait_busy_low(t);
    check_val("b_frame_len_gap", 32'(t - t_first), 32'd420);
    check_val("b_frame_done_count", 32'(fd_cnt_b), 32'd1);

    // ---- two queued frames separated by a 2-bit gap ----
    repeat (3) tick();
    data_b  = 12'hABC;
    valid_b = 1'b1;
    tick();
    data_b  = 12'h123;
    tick();
    valid_b = 1'b0;
    check_val("b_queued_pending", 32'(pend_b), 32'd1);
    check_val("b_queued_ovf", 32'(ovf_b), 32'd0);
    push_bytes({8'hA5, 8'hAB, 8'hC0, 8'h6B, 8'h00}, 4);
    repeat (4) rx_one(t_last);
    push_bytes({8'hA5, 8'h12, 8'h30, 8'h22, 8'h00}, 4);
    rx_one(t2);
    check_val("b_gap_spacing", 32'(t2 - t_last), 32'd120);
    check_val("b_frame_done_before_gap", 32'(fd_cyc_b), 32'(t_last + 99));
    repeat (3) rx_one(t);
    wait_busy_low(t);
    check_val("b_second_len", 32'(t - t2), 32'd420);
    check_val("b_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
